// File: rtl/ra_lcb_strobe_seq.sv
// Multi-channel clocked strobe sequencer: per-channel delay / width / repeat counted in clk cycles.
// Optional LCB_STROBE_OVERRUN_EN adds the per-channel saturating ignored-trigger counter output ovr.
module ra_lcb_strobe_seq #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned CH_W     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_dly,
  input  logic [CNT_W-1:0]    cfg_wid,
  input  logic [CNT_W-1:0]    cfg_rpt,
  input  logic [CHANNELS-1:0] trig,
  output logic [CHANNELS-1:0] strobe,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
`ifdef LCB_STROBE_OVERRUN_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] ovr
`endif
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_rpt, w_rpt_nxt;
    logic [CNT_W-1:0] r_dly, w_dly_nxt, r_wid, w_wid_nxt;
    logic [CNT_W-1:0] r_sh_dly, r_sh_wid, r_sh_rpt;
    logic [CNT_W-1:0] w_ld_dly, w_ld_wid, w_ld_rpt;
    logic             w_wr, w_done_nxt;
    logic             r_strobe, r_busy, r_done;

    // Out-of-range cfg_ch never matches any generated channel index.
    assign w_wr     = cfg_we && (cfg_ch == CH_W'(c));
    assign w_ld_dly = w_wr ? cfg_dly : r_sh_dly;
    assign w_ld_wid = w_wr ? cfg_wid : r_sh_wid;
    assign w_ld_rpt = w_wr ? cfg_rpt : r_sh_rpt;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sh_dly <= '0;
        r_sh_wid <= '0;
        r_sh_rpt <= '0;
      end else if (w_wr) begin
        r_sh_dly <= cfg_dly;
        r_sh_wid <= cfg_wid;
        r_sh_rpt <= cfg_rpt;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_rpt    <= '0;
        r_dly    <= '0;
        r_wid    <= '0;
        r_strobe <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_rpt    <= w_rpt_nxt;
        r_dly    <= w_dly_nxt;
        r_wid    <= w_wid_nxt;
        r_strobe <= (w_state_nxt == PULSE);
        r_busy   <= (w_state_nxt != IDLE);
        r_done   <= w_done_nxt;
      end
    end

    // r_cnt holds remaining cycles minus one in the current phase.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rpt_nxt   = r_rpt;
      w_dly_nxt   = r_dly;
      w_wid_nxt   = r_wid;
      w_done_nxt  = 1'b0;
      case (r_state)
        IDLE: begin
          if (trig[c]) begin
            w_dly_nxt = w_ld_dly;
            w_wid_nxt = w_ld_wid;
            w_rpt_nxt = w_ld_rpt;
            if (w_ld_wid == '0) begin
              w_done_nxt = 1'b1;
            end else if (w_ld_dly != '0) begin
              w_state_nxt = DELAY;
              w_cnt_nxt   = w_ld_dly - CNT_W'(1);
            end else begin
              w_state_nxt = PULSE;
              w_cnt_nxt   = w_ld_wid - CNT_W'(1);
            end
          end
        end
        DELAY, GAP: begin
          if (r_cnt == '0) begin
            w_state_nxt = PULSE;
            w_cnt_nxt   = r_wid - CNT_W'(1);
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else if (r_rpt != '0) begin
            w_rpt_nxt = r_rpt - CNT_W'(1);
            if (r_dly != '0) begin
              w_state_nxt = GAP;
              w_cnt_nxt   = r_dly - CNT_W'(1);
            end else begin
              w_cnt_nxt = r_wid - CNT_W'(1);
            end
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    assign strobe[c] = r_strobe;
    assign busy[c]   = r_busy;
    assign done[c]   = r_done;

`ifdef LCB_STROBE_OVERRUN_EN
    logic [CNT_W-1:0] r_ovr;

    // Counts triggers dropped while busy; a config write to this channel clears it.
    always_ff @(posedge clk) begin
      if (reset || w_wr) begin
        r_ovr <= '0;
      end else if (trig[c] && (r_state != IDLE) && (r_ovr != '1)) begin
        r_ovr <= r_ovr + CNT_W'(1);
      end
    end

    assign ovr[c*CNT_W +: CNT_W] = r_ovr;
`endif
  end

endmodule

// File: tb/tb_ra_lcb_strobe_seq.sv
// Bench for ra_lcb_strobe_seq: queue-based timeline model checked every cycle plus literal pins.
module tb_ra_lcb_strobe_seq;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CH_W     = 2;
  localparam int          LOGN     = 2048;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cfg_we = 1'b0;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [CNT_W-1:0]    cfg_dly = '0, cfg_wid = '0, cfg_rpt = '0;
  logic [CHANNELS-1:0] trig = '0;
  logic [CHANNELS-1:0] strobe, busy, done;
`ifdef LCB_STROBE_OVERRUN_EN
  logic [CHANNELS*CNT_W-1:0] ovr;
  int ovr_m [CHANNELS];
`endif

  always #5 clk = ~clk;

  ra_lcb_strobe_seq #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_dly(cfg_dly), .cfg_wid(cfg_wid), .cfg_rpt(cfg_rpt), .trig(trig),
    .strobe(strobe), .busy(busy), .done(done)
`ifdef LCB_STROBE_OVERRUN_EN
    , .ovr(ovr)
`endif
  );

  typedef struct packed {logic s; logic b; logic d;} ent_t;
  localparam ent_t E_WAIT = '{s: 1'b0, b: 1'b1, d: 1'b0};
  localparam ent_t E_HIGH = '{s: 1'b1, b: 1'b1, d: 1'b0};
  localparam ent_t E_DONE = '{s: 1'b0, b: 1'b0, d: 1'b1};

  ent_t q [CHANNELS][$];
  int sh_dly [CHANNELS], sh_wid [CHANNELS], sh_rpt [CHANNELS];
  int e = 0;
  int checks = 0, fails = 0;
  logic [CHANNELS-1:0] s_log [LOGN], b_log [LOGN], d_log [LOGN];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: each accepted trigger expands into the list of per-cycle outputs it must produce.
  always @(posedge clk) begin
    logic [CHANNELS-1:0] xs, xb, xd;
    e++;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      bit cur_busy, wr;
      int ld, lw, lr;
      cur_busy = (q[c].size() > 0) && q[c][0].b;
      if (q[c].size() > 0) void'(q[c].pop_front());
      if (reset) begin
        q[c].delete();
        sh_dly[c] = 0; sh_wid[c] = 0; sh_rpt[c] = 0;
`ifdef LCB_STROBE_OVERRUN_EN
        ovr_m[c] = 0;
`endif
      end else begin
        wr = cfg_we && (int'(cfg_ch) == c);
        ld = wr ? int'(cfg_dly) : sh_dly[c];
        lw = wr ? int'(cfg_wid) : sh_wid[c];
        lr = wr ? int'(cfg_rpt) : sh_rpt[c];
        if (trig[c] && !cur_busy) begin
          if (lw != 0) begin
            for (int i = 0; i < ld; i++) q[c].push_back(E_WAIT);
            for (int p = 0; p <= lr; p++) begin
              for (int i = 0; i < lw; i++) q[c].push_back(E_HIGH);
              if (p < lr) for (int i = 0; i < ld; i++) q[c].push_back(E_WAIT);
            end
          end
          q[c].push_back(E_DONE);
        end
`ifdef LCB_STROBE_OVERRUN_EN
        if (trig[c] && cur_busy && ovr_m[c] < (1 << CNT_W) - 1) ovr_m[c]++;
        if (wr) ovr_m[c] = 0;
`endif
        if (wr) begin
          sh_dly[c] = int'(cfg_dly); sh_wid[c] = int'(cfg_wid); sh_rpt[c] = int'(cfg_rpt);
        end
      end
    end
    #1;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      xs[c] = (q[c].size() > 0) ? q[c][0].s : 1'b0;
      xb[c] = (q[c].size() > 0) ? q[c][0].b : 1'b0;
      xd[c] = (q[c].size() > 0) ? q[c][0].d : 1'b0;
`ifdef LCB_STROBE_OVERRUN_EN
      chk($sformatf("ovr[%0d]@%0d", c, e + 1), 32'(ovr[c*CNT_W +: CNT_W]), 32'(ovr_m[c]));
`endif
    end
    chk($sformatf("strobe@%0d", e + 1), 32'(strobe), 32'(xs));
    chk($sformatf("busy@%0d", e + 1), 32'(busy), 32'(xb));
    chk($sformatf("done@%0d", e + 1), 32'(done), 32'(xd));
    if (e + 1 < LOGN) begin
      s_log[e + 1] = strobe; b_log[e + 1] = busy; d_log[e + 1] = done;
    end
  end

  // One cycle of stimulus starting at a negedge; k is the edge that samples it.
  task automatic drive(input logic we, input int ch, input int d, input int w, input int r,
                       input logic [CHANNELS-1:0] t, output int k);
    cfg_we = we; cfg_ch = CH_W'(ch);
    cfg_dly = CNT_W'(d); cfg_wid = CNT_W'(w); cfg_rpt = CNT_W'(r);
    trig = t;
    k = e + 1;
    @(negedge clk);
    cfg_we = 1'b0; trig = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k, k2, kx;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_strobe", 32'(strobe), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);

    // Trigger with cleared config: done only.
    drive(0, 0, 0, 0, 0, 3'b001, k);
    idle(2);
    chk("nocfg_done", 32'(d_log[k+1][0]), 1);
    chk("nocfg_strobe", 32'(s_log[k+1][0]), 0);

    // Basic pulse dly=2 wid=3.
    drive(1, 0, 2, 3, 0, '0, kx);
    drive(0, 0, 0, 0, 0, 3'b001, k);
    idle(8);
    chk("basic_pre", 32'(s_log[k+2][0]), 0);
    chk("basic_first", 32'(s_log[k+3][0]), 1);
    chk("basic_last", 32'(s_log[k+5][0]), 1);
    chk("basic_post", 32'(s_log[k+6][0]), 0);
    chk("basic_done", 32'(d_log[k+6][0]), 1);
    chk("basic_busy_start", 32'(b_log[k+1][0]), 1);
    chk("basic_busy_done", 32'(b_log[k+6][0]), 0);

    // Repeat with gap on ch1: dly=1 wid=2 rpt=2.
    drive(1, 1, 1, 2, 2, '0, kx);
    drive(0, 0, 0, 0, 0, 3'b010, k);
    idle(12);
    chk("rpt_p1", 32'(s_log[k+2][1]), 1);
    chk("rpt_gap", 32'(s_log[k+4][1]), 0);
    chk("rpt_p2", 32'(s_log[k+5][1]), 1);
    chk("rpt_p3", 32'(s_log[k+9][1]), 1);
    chk("rpt_done", 32'(d_log[k+10][1]), 1);

    // Zero delay, continuous repeat.
    drive(1, 0, 0, 1, 3, '0, kx);
    drive(0, 0, 0, 0, 0, 3'b001, k);
    idle(7);
    chk("cont_first", 32'(s_log[k+1][0]), 1);
    chk("cont_last", 32'(s_log[k+4][0]), 1);
    chk("cont_done", 32'(d_log[k+5][0]), 1);

    // Shadow write while busy, then next trigger picks it up.
    drive(1, 0, 1, 2, 0, '0, kx);
    drive(0, 0, 0, 0, 0, 3'b001, k);
    drive(1, 0, 1, 5, 0, '0, kx);
    idle(6);
    chk("shadow_old_w", 32'(s_log[k+3][0]), 1);
    chk("shadow_old_end", 32'(s_log[k+4][0]), 0);
    drive(0, 0, 0, 0, 0, 3'b001, k2);
    idle(9);
    chk("shadow_new_w", 32'(s_log[k2+6][0]), 1);
    chk("shadow_new_done", 32'(d_log[k2+7][0]), 1);

    // Write bypass on ch1.
    drive(1, 1, 0, 3, 0, 3'b010, k);
    idle(5);
    chk("bypass_s", 32'(s_log[k+1][1]), 1);
    chk("bypass_done", 32'(d_log[k+4][1]), 1);

    // Out-of-range write ignored, then all channels at once.
    drive(1, 3, 0, 1, 0, '0, kx);
    drive(0, 0, 0, 0, 0, 3'b111, k);
    idle(9);
    chk("all_ch2_done", 32'(d_log[k+1][2]), 1);
    chk("all_ch1_s", 32'(s_log[k+1][1]), 1);
    chk("all_ch0_s", 32'(s_log[k+2][0]), 1);

    // Trigger held through a dly=4 wid=4 sequence: 8 ignored edges.
    drive(1, 2, 4, 4, 0, '0, kx);
    trig = 3'b100;
    k = e + 1;
    repeat (9) @(negedge clk);
    trig = '0;
    idle(2);
    chk("ovr_seq_done", 32'(d_log[k+9][2]), 1);
`ifdef LCB_STROBE_OVERRUN_EN
    chk("ovr_count", 32'(ovr[2*CNT_W +: CNT_W]), 8);
`endif

    // All fields at maximum.
    drive(1, 0, 15, 15, 15, '0, kx);
    drive(0, 0, 0, 0, 0, 3'b001, k);
    idle(485);
    chk("max_pre", 32'(s_log[k+15][0]), 0);
    chk("max_first", 32'(s_log[k+16][0]), 1);
    chk("max_done", 32'(d_log[k+481][0]), 1);

    // Reset during PULSE aborts with no done.
    drive(0, 0, 0, 0, 0, 3'b010, k);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    chk("abort_pulse", 32'(s_log[k+2][1]), 1);
    chk("abort_strobe", 32'(s_log[k+3][1]), 0);
    chk("abort_nodone3", 32'(d_log[k+3][1]), 0);
    chk("abort_nodone4", 32'(d_log[k+4][1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ra_lcb_strobe_seq.md
Name: ra_lcb_strobe_seq

Overview:
Parametrised multi-channel strobe sequencer for array timing; the clocked successor of the single-channel SDR strobe generator.
- Each channel produces programmable strobe pulses on a trigger: delay, width and repeat count are counted in clk cycles, not built from delay cells.
- Sits between the array control logic and the array shard read/write strobe inputs.
- Configuration is loaded over a simple write port and applied atomically at trigger acceptance.

Parameters:
CHANNELS, 2, number of independent strobe channels (1..8)
CNT_W, 4, width of the delay, width and repeat fields; each maximum is 2^CNT_W-1
CH_W, 1, width of cfg_ch; must be at least ceil(log2(CHANNELS)), minimum 1

Ports:
clk  in  1  array clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W  channel selected by cfg_we
cfg_dly  in  CNT_W  delay in cycles from trigger acceptance to the first strobe
cfg_wid  in  CNT_W  strobe high time in cycles; 0 means channel disabled
cfg_rpt  in  CNT_W  extra pulses after the first one
trig  in  CHANNELS  per-channel trigger, sampled only while that channel is idle
strobe  out  CHANNELS  registered strobe outputs
busy  out  CHANNELS  channel is in DELAY, PULSE or GAP
done  out  CHANNELS  one-cycle pulse when a sequence completes

Behaviour:
Reset (reset=1 at an edge):
- Next cycle: all FSMs are IDLE; strobe, busy and done are 0.
- Shadow and active config are cleared to dly=0, wid=0, rpt=0.
- Reset during an active sequence aborts it with no done pulse.

Config path:
- cfg_we=1 writes {dly,wid,rpt} into the shadow register of channel cfg_ch.
- cfg_ch >= CHANNELS: the write is ignored.
- A write while a channel is busy changes only its shadow; the running sequence is unaffected.

Trigger acceptance (channel c, edge k, IDLE, trig[c]=1):
- The active config loads from the shadow.
- If cfg_we targets c in the same cycle, the newly written values are used (write bypass).

Per-channel FSM (IDLE, DELAY, PULSE, GAP):
- IDLE with an accepted trigger, wid=0: stay IDLE; done[c]=1 in cycle k+1; no strobe.
- IDLE with an accepted trigger, wid>0: go to DELAY if dly>0, otherwise directly to PULSE.
- DELAY lasts dly cycles. PULSE lasts wid cycles with strobe[c]=1.
- After PULSE: if repeats remain, go to GAP (dly cycles, strobe 0; skipped if dly=0, giving a continuous high), then PULSE again. Otherwise go to IDLE.
- Timing: first strobe high during cycles k+1+dly .. k+dly+wid.
- Total strobe pulses = rpt+1.

Status outputs:
- done[c] is high exactly one cycle, in the cycle after the last strobe-high cycle.
- busy[c] is high from k+1 until the cycle done is high, inclusive of that cycle? No: busy is high from k+1 through the last strobe cycle and is low in the done cycle.
- trig[c] while busy[c]=1 is ignored (an overrun).
- A trigger in the same cycle that done[c] is high is accepted, since the channel is IDLE then. Back-to-back sequences therefore have one idle cycle between them.

Channel independence and counters:
- Channels are fully independent.
- Simultaneous triggers on all channels are each accepted.
- Counters are CNT_W bits, down-counting, with no wrap: a load of N yields exactly N cycles.
- dly=wid=rpt=2^CNT_W-1 must work.

Optional Feature:
Macro LCB_STROBE_OVERRUN_EN.
- Defined: adds output port ovr (CHANNELS*CNT_W wide).
  - Slice c is a saturating counter of triggers ignored while busy[c]=1.
  - The counter holds at 2^CNT_W-1.
  - It clears on reset, or when cfg_we writes channel c.
- Undefined: no ovr port, no counter logic; ignored triggers leave no trace.

Test Plan:
- Reset then status check: reset held 2 cycles, then released -> strobe=0, busy=0, done=0; a trigger before any cfg write gives done pulse at k+1 and no strobe.
- Basic pulse: write ch0 dly=2 wid=3 rpt=0, trig[0] at edge 10 -> strobe[0] high cycles 13..15, done[0] at 16, busy[0] 11..15.
- Repeat with gap: ch1 dly=1 wid=2 rpt=2, trig at 20 -> strobe[1] high 22-23, 25-26, 28-29, done at 30.
- Zero delay with continuous repeat: dly=0 wid=1 rpt=3, trig at 5 -> strobe high 6..9 continuous, done at 10.
- Shadow and bypass: cfg write wid=5 to ch0 mid-sequence -> running pulse keeps old width, next trigger uses 5; a write and trigger in the same cycle -> new values are used.
- Overrun and reset abort: trig held high during a dly=4 wid=4 sequence -> ovr[ch] counts the ignored cycles (with the macro defined); reset asserted at a PULSE cycle -> strobe 0 next cycle, no done pulse.
